// File: rtl/bist_7x7_if.sv
// bist_7x7_if: run control, stimulus and response bundle between the BIST engine and its environment
interface bist_7x7_if;
  logic       start;
  logic [6:0] rsp;
  logic [6:0] pat;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] sig;
  modport master (output start, rsp, input pat, busy, done, pass, sig);
  modport slave (input start, rsp, output pat, busy, done, pass, sig);
endinterface

// File: rtl/bist_7x7.sv
// bist_7x7: LFSR stimulus generator and MISR signature compactor for a 7-in/7-out combinational block
module bist_7x7 #(
  parameter int         N_PAT  = 127,
  parameter logic [6:0] SEED   = 7'h01,
  parameter logic [6:0] GOLDEN = 7'h00
) (
  input logic         ck,
  input logic         rst,
  bist_7x7_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [6:0] LAST = 7'(N_PAT - 1);
  state_t     state;
  logic [6:0] pat, sig, cnt;
  logic       busy, done, pass;
  logic [6:0] pat_nxt, sig_nxt;
  logic       last;
  assign pat_nxt = {pat[5:0], pat[6] ^ pat[5]};
  assign sig_nxt = {sig[5:0], sig[6] ^ sig[5]} ^ bus.rsp;
  assign last    = cnt == LAST;
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pat   <= '0;
      sig   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          sig <= sig_nxt;
          cnt <= cnt + 7'd1;
          pat <= last ? '0 : pat_nxt;
          if (last) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= sig_nxt == GOLDEN;
          end
        end
        default: if (bus.start) begin
          state <= RUN;
          pat   <= SEED;
          sig   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.pat  = pat;
  assign bus.sig  = sig;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.pass = pass;
endmodule

// File: doc/bist_7x7.md
BIST_7X7 -- requirements
Module: bist_7x7

Interface
REQ-001: Parameter N_PAT, default 127, is the number of patterns per run; legal range 1..127.
REQ-002: Parameter SEED, default 7'h01, is the LFSR start value; SHALL be nonzero.
REQ-003: Parameter GOLDEN, default 7'h00, is the expected final signature.
REQ-004: Port CK, input, 1 bit, is the single clock; all state changes on the rising edge.
REQ-005: Port RST, input, 1 bit, is the reset; it is asynchronous and active-high.
REQ-006: Port START, input, 1 bit, requests a run; sampled in IDLE and DONE only.
REQ-007: Port RSP, input, 7 bits, is the response from the 7-in/7-out combinational circuit under test.
REQ-008: Port PAT, output, 7 bits, is the stimulus to the circuit under test; registered.
REQ-009: Port BUSY, output, 1 bit, is high while in RUN.
REQ-010: Port DONE, output, 1 bit, is high while in DONE.
REQ-011: Port PASS, output, 1 bit, is the registered comparison SIG==GOLDEN; valid when DONE=1.
REQ-012: Port SIG, output, 7 bits, is the MISR contents.

Function
REQ-013: FSM states SHALL be IDLE, RUN, DONE; no other reachable states.
REQ-014: In IDLE or DONE with START=1 at an edge, the block SHALL enter RUN, load PAT=SEED, clear SIG=0, clear count=0, and clear PASS=0.
REQ-015: LFSR (polynomial x^7+x^6+1) SHALL advance PAT_next = {PAT[5:0], PAT[6]^PAT[5]} on every RUN edge; with SEED=01 the sequence SHALL be 01,02,04,08,10,20,41,03; period 127; wraps to SEED.
REQ-016: On every RUN edge the MISR SHALL update SIG_next = {SIG[5:0], SIG[6]^SIG[5]} XOR RSP, with RSP sampled at that edge; RSP responds to the PAT value held in that cycle.
REQ-017: A 7-bit counter SHALL increment on each RUN edge; the edge performing capture number N_PAT SHALL move the FSM to DONE.
REQ-018: On the RUN->DONE edge, PASS SHALL load (SIG_next == GOLDEN), and PAT SHALL load 0.
REQ-019: Latency: START sampled at edge E0 -> BUSY=1 from E0 through E_N_PAT; DONE=1 after edge E_N_PAT; exactly N_PAT captures per run.
REQ-020: START SHALL be ignored during RUN; the run is not extended or restarted.
REQ-021: DONE, PASS, and SIG SHALL hold in DONE until START=1 (restart) or RST.
REQ-022: PAT SHALL be 0 in IDLE and DONE.
REQ-023: For N_PAT=1, exactly one capture SHALL occur and DONE SHALL assert after E1.
REQ-024: For N_PAT=127, PAT SHALL visit all 127 nonzero values exactly once.

Reset
REQ-025: RST=1 SHALL immediately force the state to IDLE, PAT=0, SIG=0, count=0, BUSY=0, DONE=0, and PASS=0, independent of CK.
REQ-026: RST asserted mid-RUN SHALL abort the run with no partial DONE/PASS; after release, START is required to begin.
REQ-027: The first edge after RST deasserts SHALL behave as IDLE (START sampled).

Verification
REQ-028: SEED=01, N_PAT=8, RSP=0, START pulse -> PAT over RUN = 01,02,04,08,10,20,41,03; DONE after 8th edge; SIG=00; PASS=1 (GOLDEN=00).
REQ-029: N_PAT=2, RSP=7F constant -> SIG=7F after E1 and SIG=01 after E2; GOLDEN=01 -> PASS=1; GOLDEN=00 -> PASS=0.
REQ-030: N_PAT=1 -> BUSY high for exactly one cycle; one capture; DONE=1 next cycle.
REQ-031: RST pulsed at the 4th RUN cycle of an N_PAT=8 run -> all outputs 0 immediately; state IDLE; no DONE until a new START.
REQ-032: START held high through RUN and then DONE -> run length unaffected; the DONE-state edge with START=1 restarts (PAT=SEED, SIG=0, PASS=0, DONE=0).
REQ-033: N_PAT=127 with RSP=PAT looped back -> 127 distinct PAT values, no repeats; DONE after exactly 127 edges.
